// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the weight bank receiver: default geometry of the
// bank and the controller state encoding.
package nn_ctrl_pkg;

  localparam int NUM_UNITS = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/start_edge_detect.sv
// Registered rising-edge detector for the loader start request.
// Ports:
//   clk        in   single clock, posedge
//   reset      in   asynchronous, active-high
//   start      in   level start request
//   start_edge out  high for the cycle in which start rises
module start_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic start_edge
);

  logic start_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
    end else begin
      start_prev <= start;
    end
  end

  // A level held high produces a single edge.
  assign start_edge = start & ~start_prev;

endmodule

// File: rtl/weight_bank_receiver.sv
// Receives NUM_UNITS words from the ROM loader into a register bank and, on a
// start request, replays them to the network datapath over a valid/ready
// stream before returning to idle.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   rom_output, address,
//   writeData                  loader write interface (one strobe per word)
//   start_network_controller   start request from the loader (edge-triggered)
//   weight_out, weight_index,
//   weight_valid, weight_ready streamed word, its index, and handshake
//   loaded_mask                bit i set once bank[i] has been written
//   busy                       high while streaming
//   done                       one-cycle pulse after the last beat
//   error                      sticky: start without full bank, or write while busy
module weight_bank_receiver
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_UNITS = nn_ctrl_pkg::NUM_UNITS,
  parameter int DATA_W    = nn_ctrl_pkg::DATA_W,
  parameter int ADDR_W    = nn_ctrl_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    rom_output,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 writeData,
  input  logic                 start_network_controller,
  output logic [DATA_W-1:0]    weight_out,
  output logic [ADDR_W-1:0]    weight_index,
  output logic                 weight_valid,
  input  logic                 weight_ready,
  output logic [NUM_UNITS-1:0] loaded_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_UNITS - 1);

  state_t                 state, state_nxt;
  logic [DATA_W-1:0]      bank [NUM_UNITS];
  logic [ADDR_W-1:0]      index;
  logic [NUM_UNITS-1:0]   wr_onehot;
  logic                   start_edge;
  logic                   bank_full;
  logic                   beat;

  start_edge_detect u_start_edge (
    .clk        (clk),
    .reset      (reset),
    .start      (start_network_controller),
    .start_edge (start_edge)
  );

  // The fullness check folds in a write landing in the same cycle as the
  // start edge, so the loader can issue its last write and start together.
  always_comb begin
    wr_onehot          = '0;
    wr_onehot[address] = writeData;
  end

  assign bank_full = &(loaded_mask | wr_onehot);
  assign beat      = weight_valid & weight_ready;

  always_comb begin
    state_nxt    = state;
    weight_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && bank_full) state_nxt = STREAM;
      end
      STREAM: begin
        weight_valid = 1'b1;
        busy         = 1'b1;
        if (beat && (index == LAST_IDX)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Index only moves on a beat and wraps to 0 after the last one, so it is
  // already 0 whenever a new stream begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= '0;
    end else if (state == STREAM && beat) begin
      index <= index + ADDR_W'(1);
    end
  end

  // Writes are accepted only in IDLE, so the bank is frozen while streaming
  // and the stream outputs stay stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) bank[i] <= '0;
    end else if (state == IDLE && writeData) begin
      bank[address] <= rom_output;
    end
  end

  // Mask is cleared on leaving DONE so every load needs a complete rewrite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded_mask <= '0;
    end else if (state == DONE) begin
      loaded_mask <= '0;
    end else if (state == IDLE) begin
      loaded_mask <= loaded_mask | wr_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((writeData && state != IDLE) ||
                 (state == IDLE && start_edge && !bank_full)) begin
      error <= 1'b1;
    end
  end

  assign weight_out   = bank[index];
  assign weight_index = index;

endmodule

// File: tb/tb_weight_bank_receiver.sv
module tb_weight_bank_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_output = '0;
  logic [1:0]  address = '0;
  logic        writeData = 1'b0;
  logic        start_network_controller = 1'b0;
  logic [31:0] weight_out;
  logic [1:0]  weight_index;
  logic        weight_valid;
  logic        weight_ready = 1'b1;
  logic [3:0]  loaded_mask;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fails  = 0;
  int beat_cnt = 0;
  logic [31:0] exp_data [4];

  weight_bank_receiver dut (
    .clk                      (clk),
    .reset                    (reset),
    .rom_output               (rom_output),
    .address                  (address),
    .writeData                (writeData),
    .start_network_controller (start_network_controller),
    .weight_out               (weight_out),
    .weight_index             (weight_index),
    .weight_valid             (weight_valid),
    .weight_ready             (weight_ready),
    .loaded_mask              (loaded_mask),
    .busy                     (busy),
    .done                     (done),
    .error                    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (weight_valid && weight_ready) beat_cnt <= beat_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    writeData = 1'b0;
    start_network_controller = 1'b0;
    weight_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_word(input logic [1:0] a, input logic [31:0] d);
    writeData = 1'b1;
    address = a;
    rom_output = d;
    @(negedge clk);
    writeData = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = 32'hA0 + 32'(i);
      write_word(2'(i), exp_data[i]);
    end
  endtask

  task automatic pulse_start();
    start_network_controller = 1'b1;
    @(negedge clk);
    start_network_controller = 1'b0;
  endtask

  // Called at the negedge where beat k should be presented; ends one cycle later.
  task automatic expect_beat(input string tag, input int k);
    check_eq({tag, " valid"}, 32'(weight_valid), 1);
    check_eq({tag, " busy"}, 32'(busy), 1);
    check_eq({tag, " index"}, 32'(weight_index), 32'(k));
    check_eq({tag, " data"}, weight_out, exp_data[k]);
    @(negedge clk);
  endtask

  // Streams from the current beat k0 to the end, optionally stalling, then
  // checks the done pulse and the mask clear.
  task automatic stream_rest(input string tag, input int k0, input int stall_beat, input int stall_len);
    int start_cnt;
    start_cnt = beat_cnt;
    for (int k = k0; k < 4; k++) begin
      if (k == stall_beat) begin
        weight_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check_eq({tag, " stall valid"}, 32'(weight_valid), 1);
          check_eq({tag, " stall index"}, 32'(weight_index), 32'(k));
          check_eq({tag, " stall data"}, weight_out, exp_data[k]);
        end
        weight_ready = 1'b1;
      end
      expect_beat(tag, k);
    end
    check_eq({tag, " beats"}, 32'(beat_cnt - start_cnt), 32'(4 - k0));
    check_eq({tag, " done"}, 32'(done), 1);
    check_eq({tag, " valid after last"}, 32'(weight_valid), 0);
    @(negedge clk);
    check_eq({tag, " done pulse width"}, 32'(done), 0);
    check_eq({tag, " mask cleared"}, 32'(loaded_mask), 0);
    check_eq({tag, " busy idle"}, 32'(busy), 0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check_eq("reset valid", 32'(weight_valid), 0);
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset done", 32'(done), 0);
    check_eq("reset error", 32'(error), 0);
    check_eq("reset mask", 32'(loaded_mask), 0);
    check_eq("reset index", 32'(weight_index), 0);
    check_eq("reset data", weight_out, 0);

    // 1: basic load and full-bandwidth stream
    load_all();
    check_eq("t1 mask full", 32'(loaded_mask), 32'hF);
    pulse_start();
    stream_rest("t1", 0, -1, 0);
    check_eq("t1 error", 32'(error), 0);

    // 2: start with incomplete bank
    do_reset();
    write_word(2'd0, 32'hA0);
    write_word(2'd1, 32'hA1);
    write_word(2'd2, 32'hA2);
    pulse_start();
    check_eq("t2 error", 32'(error), 1);
    check_eq("t2 valid", 32'(weight_valid), 0);
    check_eq("t2 mask", 32'(loaded_mask), 32'h7);
    repeat (3) @(negedge clk);
    check_eq("t2 valid later", 32'(weight_valid), 0);
    check_eq("t2 busy later", 32'(busy), 0);

    // 3: backpressure on beat 1
    do_reset();
    load_all();
    pulse_start();
    stream_rest("t3", 0, 1, 3);

    // 4: write during stream is dropped
    do_reset();
    load_all();
    pulse_start();
    writeData = 1'b1;
    address = 2'd2;
    rom_output = 32'hFF;
    expect_beat("t4", 0);
    writeData = 1'b0;
    check_eq("t4 error", 32'(error), 1);
    stream_rest("t4", 1, -1, 0);
    check_eq("t4 error sticky", 32'(error), 1);

    // 5: reset mid-stream
    do_reset();
    load_all();
    pulse_start();
    expect_beat("t5", 0);
    expect_beat("t5", 1);
    reset = 1'b1;
    #1;
    check_eq("t5 valid drop", 32'(weight_valid), 0);
    check_eq("t5 busy drop", 32'(busy), 0);
    check_eq("t5 mask drop", 32'(loaded_mask), 0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("t5 no done", 32'(done), 0);
    @(negedge clk);
    check_eq("t5 no done later", 32'(done), 0);
    load_all();
    pulse_start();
    stream_rest("t5 reload", 0, -1, 0);

    // 6: last write coincides with start edge; start then held high
    do_reset();
    load_all();
    do_reset();
    exp_data[3] = 32'hB3;
    write_word(2'd0, exp_data[0]);
    write_word(2'd1, exp_data[1]);
    write_word(2'd2, exp_data[2]);
    writeData = 1'b1;
    address = 2'd3;
    rom_output = 32'hB3;
    start_network_controller = 1'b1;
    @(negedge clk);
    writeData = 1'b0;
    stream_rest("t6", 0, -1, 0);
    repeat (3) @(negedge clk);
    check_eq("t6 held start no restart", 32'(weight_valid), 0);
    check_eq("t6 held start no error", 32'(error), 0);
    start_network_controller = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
